sram_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for one `SRAM_64k` instance (16K words × 32 bit) in the face-detection SoC.
- Requester 0 is the CPU data path; requester 1 is the detection accelerator.
- Accepts word-addressed read/write requests on a valid/ready handshake and picks a winner round-robin.
- Drives the SRAM pins for exactly one access per cycle and returns the response to the winning requester, with full back-pressure support.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 23 ++
 rtl/sram_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and the request record carried through the ACC stage.
package sram_arb_pkg;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_q remembers the most recent winner.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);
    logic last_q, last_d;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
        last_d = accept_i ? grant_o[1] : last_q;
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= 1'b1;
        else       last_q <= last_d;
    end
endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: ISSUE -> ACC (SRAM access) -> RSP pipeline.
module sram_arbiter #(
    parameter int NUM_REQ = sram_arb_pkg::NUM_REQ,
    parameter int ADDR_W  = sram_arb_pkg::ADDR_W,
    parameter int DATA_W  = sram_arb_pkg::DATA_W
) (
    input  logic                              CK,
    input  logic                              RST,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]  req_wstrb,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [DATA_W-1:0]                 resp_rdata,
    output logic                              sram_cs,
    output logic                              sram_oe,
    output logic [DATA_W/8-1:0]               sram_web,
    output logic [ADDR_W-1:0]                 sram_a,
    output logic [DATA_W-1:0]                 sram_di,
    input  logic [DATA_W-1:0]                 sram_do
);
    import sram_arb_pkg::*;

    logic [1:0]  grant;
    logic        win, accept, acc_go, rsp_fire;
    sram_req_t   mux_req;

    logic        acc_v_q, acc_v_d;
    sram_req_t   acc_q, acc_d;
    logic        acc_id_q, acc_id_d;
    logic        rsp_v_q, rsp_v_d;
    logic        rsp_first_q, rsp_first_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    rr_arb2 u_arb (
        .clk_i    (CK),
        .rst_i    (RST),
        .valid_i  (req_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Handshake: ACC may advance when empty, RSP is empty, or RSP fires this cycle.
    always_comb begin
        rsp_fire  = rsp_v_q && resp_ready[rsp_id_q];
        acc_go    = !acc_v_q || !rsp_v_q || rsp_fire;
        req_ready = (RST || !acc_go) ? '0 : grant;
        accept    = |req_ready;
        win       = grant[1];
        mux_req.write = req_write[win];
        mux_req.addr  = req_addr[win];
        mux_req.wstrb = req_wstrb[win];
        mux_req.wdata = req_wdata[win];
    end

    // Next state for ACC and RSP; a stalled ACC keeps its contents untouched.
    always_comb begin
        acc_v_d     = acc_v_q;
        acc_d       = acc_q;
        acc_id_d    = acc_id_q;
        rsp_v_d     = rsp_v_q;
        rsp_first_d = rsp_first_q;
        rsp_id_d    = rsp_id_q;
        rsp_wr_d    = rsp_wr_q;
        hold_d      = hold_q;
        if (acc_go) begin
            acc_v_d = accept;
            if (accept) begin
                acc_d    = mux_req;
                acc_id_d = win;
            end
        end
        if (acc_v_q && acc_go) begin
            rsp_v_d     = 1'b1;
            rsp_first_d = 1'b1;
            rsp_id_d    = acc_id_q;
            rsp_wr_d    = acc_q.write;
        end else if (rsp_fire) begin
            rsp_v_d = 1'b0;
        end else begin
            rsp_first_d = 1'b0;
        end
        // sram_do is only trustworthy in the first RSP cycle, so keep a copy.
        if (rsp_v_q && rsp_first_q && !rsp_fire) hold_d = sram_do;
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge CK) begin
        if (RST) begin
            acc_v_q     <= 1'b0;
            acc_q       <= '0;
            acc_id_q    <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_first_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_wr_q    <= 1'b0;
            hold_q      <= '0;
        end else begin
            acc_v_q     <= acc_v_d;
            acc_q       <= acc_d;
            acc_id_q    <= acc_id_d;
            rsp_v_q     <= rsp_v_d;
            rsp_first_q <= rsp_first_d;
            rsp_id_q    <= rsp_id_d;
            rsp_wr_q    <= rsp_wr_d;
            hold_q      <= hold_d;
        end
    end

    // SRAM pins and response outputs; write responses carry zero data.
    always_comb begin
        sram_cs    = acc_v_q && acc_go;
        sram_web   = acc_q.write ? ~acc_q.wstrb : '1;
        sram_a     = acc_q.addr;
        sram_di    = acc_q.wdata;
        resp_valid = '0;
        resp_valid[rsp_id_q] = rsp_v_q;
        sram_oe    = rsp_v_q && rsp_first_q && !rsp_wr_q;
        resp_rdata = '0;
        if (rsp_v_q && !rsp_wr_q) resp_rdata = rsp_first_q ? sram_do : hold_q;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter with a transaction-level reference model.
module tb_sram_arbiter;
    logic              CK = 1'b0;
    logic              RST;
    logic [1:0]        req_valid, req_ready, req_write, resp_valid, resp_ready;
    logic [1:0][13:0]  req_addr;
    logic [1:0][3:0]   req_wstrb;
    logic [1:0][31:0]  req_wdata;
    logic [31:0]       resp_rdata, sram_di, sram_do;
    logic              sram_cs, sram_oe;
    logic [3:0]        sram_web;
    logic [13:0]       sram_a;

    sram_arbiter dut (
        .CK(CK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .sram_cs(sram_cs), .sram_oe(sram_oe),
        .sram_web(sram_web), .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    always #5 CK = ~CK;

    // SRAM device: data out the cycle after a read, garbage otherwise.
    logic [31:0] sram [0:16383];
    logic        fill = 1'b0, pl_en = 1'b0;
    logic [13:0] pl_a = '0;
    logic [31:0] pl_d = '0;
    initial sram_do = '0;
    always @(posedge CK) begin
        if (fill) for (int i = 0; i < 16384; i++) sram[i] <= 32'(i) * 32'h9E3779B1;
        if (pl_en) sram[pl_a] <= pl_d;
        if (sram_cs) begin
            if (sram_web == 4'hF) sram_do <= sram[sram_a];
            else begin
                for (int b = 0; b < 4; b++)
                    if (!sram_web[b]) sram[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
                sram_do <= $urandom;
            end
        end else sram_do <= $urandom;
    end

    int n_vec = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: in-order list of accepted transactions; capacity two (one
    // access waiting/issuing, one response outstanding).
    typedef struct {
        bit id; bit wr; logic [13:0] a; logic [3:0] s; logic [31:0] d;
        logic [31:0] rd; bit issued; bit first;
    } txn_t;
    txn_t        q[$];
    logic [31:0] refm [0:16383];
    bit          m_last = 1'b1;
    bit          gnt_log[$];
    logic [1:0]  acc_mask;
    logic [31:0] last_fire_rd;
    logic [3:0]  last_web;
    int          cyc = 0, acc_cyc = 0, fire_cyc = 0;

    task automatic step();
        txn_t t;
        int n;
        bit hr, pend, fire, win, can, ecs;
        logic [1:0] er, erv;
        logic [31:0] erd;
        logic [3:0] ew;
        @(negedge CK);
        n    = q.size();
        hr   = (n > 0) && q[0].issued;
        pend = (n > 0) && !q[n-1].issued;
        fire = hr && resp_ready[q[0].id];
        ecs  = pend && (!hr || fire);
        win  = (req_valid == 2'b11) ? !m_last : req_valid[1];
        can  = !RST && ((n < 2) || fire);
        er   = (req_valid != 2'b00 && can) ? (2'b01 << win) : 2'b00;
        erv  = hr ? (2'b01 << q[0].id) : 2'b00;
        erd  = (hr && !q[0].wr) ? q[0].rd : 32'h0;
        chk("ready", req_ready, er);
        chk("resp_valid", resp_valid, erv);
        chk("cs", sram_cs, ecs);
        chk("oe", sram_oe, hr && q[0].first && !q[0].wr);
        chk("rdata", resp_rdata, erd);
        if (ecs) begin
            t  = q[n-1];
            ew = t.wr ? ~t.s : 4'hF;
            chk("sram_a", sram_a, t.a);
            chk("sram_web", sram_web, ew);
            if (t.wr) begin
                chk("sram_di", sram_di, t.d);
                last_web = sram_web;
            end
        end
        if (fire) last_fire_rd = resp_rdata;
        acc_mask = er;
        @(posedge CK);
        cyc++;
        if (hr) begin t = q[0]; t.first = 1'b0; q[0] = t; end
        if (ecs) begin
            t = q[n-1];
            t.issued = 1'b1; t.first = 1'b1; t.rd = refm[t.a];
            if (t.wr) for (int b = 0; b < 4; b++)
                if (t.s[b]) refm[t.a][8*b +: 8] = t.d[8*b +: 8];
            q[n-1] = t;
        end
        if (fire) begin void'(q.pop_front()); fire_cyc = cyc; end
        if (RST) begin
            q.delete();
            m_last = 1'b1;
        end else if (er != 2'b00) begin
            t = '{id: win, wr: req_write[win], a: req_addr[win], s: req_wstrb[win],
                  d: req_wdata[win], rd: 32'h0, issued: 1'b0, first: 1'b0};
            q.push_back(t);
            m_last = win;
            gnt_log.push_back(win);
            acc_cyc = cyc;
        end
        #1;
    endtask

    task automatic drive(input int i, input bit v, input bit w, input logic [13:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        req_valid[i] = v; req_write[i] = w; req_addr[i] = a;
        req_wstrb[i] = s; req_wdata[i] = d;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        refm[a] = d; pl_a = a; pl_d = d; pl_en = 1'b1;
        step();
        pl_en = 1'b0;
    endtask

    task automatic rst_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 2'b00);
        chk({tag, "_rvalid"}, resp_valid, 2'b00);
        chk({tag, "_cs"}, sram_cs, 1'b0);
        chk({tag, "_oe"}, sram_oe, 1'b0);
        chk({tag, "_web"}, sram_web, 4'hF);
        chk({tag, "_a"}, sram_a, 14'h0);
        chk({tag, "_di"}, sram_di, 32'h0);
        chk({tag, "_rdata"}, resp_rdata, 32'h0);
    endtask

    initial begin
        RST = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
        req_wstrb = '0; req_wdata = '0; resp_ready = 2'b11;
        for (int i = 0; i < 16384; i++) refm[i] = 32'(i) * 32'h9E3779B1;
        fill = 1'b1; step(); fill = 1'b0; step();
        rst_outputs("reset");
        preload(14'h0010, 32'hDEADBEEF);
        preload(14'h3FFF, 32'hAABBCCDD);
        preload(14'h0020, 32'hA5A5A5A5);
        RST = 1'b0;

        // single read
        drive(0, 1, 0, 14'h0010, 4'h0, 32'h0);
        step();
        chk("rd_accept", acc_mask, 2'b01);
        drive(0, 0, 0, 14'h0, 4'h0, 32'h0);
        repeat (4) step();
        chk("rd_data", last_fire_rd, 32'hDEADBEEF);
        chk("rd_latency", 32'(fire_cyc - acc_cyc), 32'd2);

        // byte write then readback
        drive(1, 1, 1, 14'h3FFF, 4'b0101, 32'h12345678);
        step();
        drive(1, 1, 0, 14'h3FFF, 4'h0, 32'h0);
        step();
        drive(1, 0, 0, 14'h0, 4'h0, 32'h0);
        repeat (4) step();
        chk("bw_web", last_web, 4'b1010);
        chk("bw_readback", last_fire_rd, 32'hAA34CC78);

        // contention right after reset
        RST = 1'b1; step(); RST = 1'b0;
        gnt_log.delete();
        drive(0, 1, 0, 14'h0040, 4'h0, 32'h0);
        drive(1, 1, 0, 14'h0080, 4'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            for (int i = 0; i < 2; i++)
                if (acc_mask[i]) req_addr[i] = 14'($urandom_range(0, 255));
        end
        drive(0, 0, 0, 14'h0, 4'h0, 32'h0);
        drive(1, 0, 0, 14'h0, 4'h0, 32'h0);
        repeat (4) step();
        chk("cont_count", gnt_log.size(), 6);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++)
            chk("cont_grant", gnt_log[k], k % 2);

        // back-pressure on requester 0 with requester 1 queued behind
        resp_ready = 2'b00;
        drive(0, 1, 0, 14'h0020, 4'h0, 32'h0);
        step();
        drive(0, 0, 0, 14'h0, 4'h0, 32'h0);
        drive(1, 1, 0, 14'h0021, 4'h0, 32'h0);
        step();
        drive(1, 0, 0, 14'h0, 4'h0, 32'h0);
        drive(0, 1, 0, 14'h0022, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold", resp_rdata, 32'hA5A5A5A5);
            chk("bp_cs", sram_cs, 1'b0);
            chk("bp_ready", req_ready, 2'b00);
        end
        resp_ready = 2'b11;
        step();
        chk("bp_release", last_fire_rd, 32'hA5A5A5A5);
        drive(0, 0, 0, 14'h0, 4'h0, 32'h0);
        repeat (4) step();

        // reset while a write sits in ACC
        drive(0, 1, 1, 14'h0030, 4'hF, 32'h11112222);
        step();
        drive(0, 0, 0, 14'h0, 4'h0, 32'h0);
        RST = 1'b1;
        step();
        rst_outputs("midrst");
        RST = 1'b0;
        gnt_log.delete();
        drive(0, 1, 0, 14'h0031, 4'h0, 32'h0);
        drive(1, 1, 0, 14'h0032, 4'h0, 32'h0);
        step();
        chk("midrst_tie", gnt_log.size() > 0 ? gnt_log[0] : 1'b1, 1'b0);
        drive(0, 0, 0, 14'h0, 4'h0, 32'h0);
        repeat (3) step();
        drive(1, 0, 0, 14'h0, 4'h0, 32'h0);
        repeat (4) step();

        // random traffic on a small address window to exercise hazards
        for (int k = 0; k < 3000; k++) begin
            RST = ($urandom_range(0, 499) == 0);
            resp_ready[0] = ($urandom_range(0, 3) != 0);
            resp_ready[1] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || acc_mask[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        drive(i, 1, 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15)),
                              4'($urandom_range(0, 15)), $urandom);
                    else
                        drive(i, 0, 0, 14'h0, 4'h0, 32'h0);
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
